// File: rtl/spi_slave_rx_if.sv
// Bundle of SPI link lines and parallel receive-side signals for spi_slave_rx.
// The master modport is the SPI master/consumer view; the slave modport is the receiver.
interface spi_slave_rx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) ();
    logic                  spi_cs_l;
    logic                  spi_sclk;
    logic                  spi_data;
    logic                  rd_ack;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  data_valid;
    logic                  frame_err;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  counter;
    logic                  overrun;

    modport master (
        output spi_cs_l, spi_sclk, spi_data, rd_ack,
        input  dataout, data_valid, frame_err, busy, counter, overrun
    );

    modport slave (
        input  spi_cs_l, spi_sclk, spi_data, rd_ack,
        output dataout, data_valid, frame_err, busy, counter, overrun
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver: oversamples cs/sclk/data in clk, shifts MSB-first words, strobes data_valid.
// Optional sticky overrun detection is built when SPI_RX_OVERRUN_EN is defined.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for chip select to go active, counter held at 0
// RECV  | frame in progress, one bit shifted per sclk rising edge
// DONE  | word delivered, further sclk edges ignored until cs rises
module spi_slave_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input logic          clk,
    input logic          reset,
    spi_slave_rx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                state;
    logic                  cs_s1, cs_s2, cs_s3;
    logic                  sclk_s1, sclk_s2, sclk_s3;
    logic                  data_s1, data_s2;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] dataout_q;
    logic                  data_valid_q;
    logic                  frame_err_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  counter_q;

    logic sclk_rise;
    logic cs_rise;
    logic cs_act;

    // cs chain resets high so leaving reset never looks like a cs edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            cs_s1   <= bus.spi_cs_l;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            sclk_s1 <= bus.spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            data_s1 <= bus.spi_data;
            data_s2 <= data_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign cs_rise   = cs_s2 & ~cs_s3;
    assign cs_act    = ~cs_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            shreg        <= '0;
            dataout_q    <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            counter_q    <= '0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    counter_q <= '0;
                    if (cs_act) begin
                        state  <= RECV;
                        busy_q <= 1'b1;
                    end
                end
                RECV: begin
                    // cs release takes priority over a coincident sclk edge
                    if (cs_rise) begin
                        if (counter_q != '0) begin
                            frame_err_q <= 1'b1;
                        end
                        counter_q <= '0;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        shreg <= {shreg[DATA_WIDTH-2:0], data_s2};
                        if (counter_q == LAST_BIT) begin
                            dataout_q    <= {shreg[DATA_WIDTH-2:0], data_s2};
                            data_valid_q <= 1'b1;
                            counter_q    <= '0;
                            busy_q       <= 1'b0;
                            state        <= DONE;
                        end else begin
                            counter_q <= counter_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    counter_q <= '0;
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    counter_q <= '0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.dataout    = dataout_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
    assign bus.counter    = counter_q;

`ifdef SPI_RX_OVERRUN_EN
    logic unread;
    logic overrun_q;

    // a word landing together with rd_ack still counts as unread
    always_ff @(posedge clk) begin
        if (!reset) begin
            unread    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (data_valid_q) begin
                unread <= 1'b1;
                if (unread) begin
                    overrun_q <= 1'b1;
                end
            end else if (bus.rd_ack) begin
                unread <= 1'b0;
            end
        end
    end

    assign bus.overrun = overrun_q;
`else
    logic unused_rd_ack;

    assign unused_rd_ack = bus.rd_ack;
    assign bus.overrun   = 1'b0;
`endif

endmodule
